ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the EX stage. It consumes operands delivered by the ID/EX pipeline register and holds the pipeline through a valid/ready handshake while it iterates. It sits beside the single-cycle ALU: the hazard unit stalls IF/ID/ID-EX while `busy` is high, and the result is forwarded into EX/MEM on the output handshake.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_datapath.sv | 67 ++++++
 rtl/ex_muldiv.sv | 120 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } muldiv_state_e;

   localparam int          MULDIV_ITERS = 32;
   localparam int          MULDIV_LAT   = 34;
   localparam logic [31:0] DIV0_Q       = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_Q        = 32'h8000_0000;

endpackage

// File: rtl/muldiv_datapath.sv
// 64-bit accumulator for shift-add multiply and restoring divide, plus sign fix-up.
// Divide stepping and remainder/quotient negation exist only with MULDIV_DIV_EN.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_mul_step,
   input  logic            i_div_step,
   input  logic            i_is_div,
   input  logic            i_neg,
   input  logic            i_hi,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_word
);

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opb;

   // Multiplier sits in the low half and drains out the bottom as the product fills in.
   logic [XLEN:0]     w_add;
   assign w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : {XLEN{1'b0}})};

`ifdef MULDIV_DIV_EN
   // Partial remainder in the high half, quotient bits shift in at the bottom.
   logic [XLEN+1:0]   w_trial;
   logic [2*XLEN-1:0] w_div_nxt;
   assign w_trial   = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_opb};
   assign w_div_nxt = w_trial[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
`else
   logic w_unused_div;
   assign w_unused_div = i_div_step;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_opb <= '0;
      end else if (i_load) begin
         r_acc <= {{XLEN{1'b0}}, i_a};
         r_opb <= i_b;
      end else if (i_mul_step) begin
         r_acc <= {w_add, r_acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      end else if (i_div_step) begin
         r_acc <= w_div_nxt;
`endif
      end
   end

   logic [2*XLEN-1:0] w_full;
   logic [XLEN-1:0]   w_sel;
   assign w_full = (i_neg && !i_is_div) ? (~r_acc + 1'b1) : r_acc;
   assign w_sel  = i_hi ? w_full[2*XLEN-1:XLEN] : w_full[XLEN-1:0];

`ifdef MULDIV_DIV_EN
   assign o_word = (i_neg && i_is_div) ? (~w_sel + 1'b1) : w_sel;
`else
   assign o_word = w_sel;
`endif

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RV32M mul/div: FSM, iteration counter, handshakes, special cases.
// Define MULDIV_DIV_EN to build the divide path; otherwise ops 4-7 finish at once with 0.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      out_rd_addr,
   output logic            busy
);

   muldiv_state_e r_state, w_state_nxt;
   logic [4:0]      r_cnt;
   logic            r_neg, r_hi, r_is_div;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_result;

   muldiv_op_e w_op;
   logic       w_accept, w_s1, w_s2, w_neg, w_hi;
   logic       w_special;
   logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res, w_fix_word;

   assign w_op     = muldiv_op_e'(op);
   assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

   assign w_s1 = rs1_data[XLEN-1] &&
                 (w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM);
   assign w_s2 = rs2_data[XLEN-1] && (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM);
   assign w_a_mag = w_s1 ? (~rs1_data + 1'b1) : rs1_data;
   assign w_b_mag = w_s2 ? (~rs2_data + 1'b1) : rs2_data;

   // Remainder takes the dividend's sign; everything else takes the XOR of operand signs.
   assign w_neg = (w_op == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
   assign w_hi  = (w_op != OP_MUL) && (w_op != OP_DIV) && (w_op != OP_DIVU);

`ifdef MULDIV_DIV_EN
   logic w_div0, w_ovf;
   assign w_div0 = op[2] && (rs2_data == '0);
   assign w_ovf  = (w_op == OP_DIV || w_op == OP_REM) &&
                   (rs1_data == OVF_Q) && (rs2_data == DIV0_Q);
   assign w_special     = w_div0 || w_ovf;
   assign w_special_res = w_div0 ? (op[1] ? rs1_data : DIV0_Q)
                                 : (op[1] ? {XLEN{1'b0}} : OVF_Q);
`else
   assign w_special     = op[2];
   assign w_special_res = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : (op[2] ? S_DIV : S_MUL);
         S_MUL,
         S_DIV:  if (r_cnt == 5'(MULDIV_ITERS - 1)) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_DONE;
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_hi     <= 1'b0;
         r_is_div <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt    <= '0;
            r_neg    <= w_neg;
            r_hi     <= w_hi;
            r_is_div <= op[2];
            r_rd     <= rd_addr;
            if (w_special) r_result <= w_special_res;
         end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt + 5'd1;
         end else if (r_state == S_FIX) begin
            r_result <= w_fix_word;
         end
      end
   end

   muldiv_datapath #(.XLEN(XLEN)) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_mul_step (r_state == S_MUL),
      .i_div_step (r_state == S_DIV),
      .i_is_div   (r_is_div),
      .i_neg      (r_neg),
      .i_hi       (r_hi),
      .i_a        (w_a_mag),
      .i_b        (w_b_mag),
      .o_word     (w_fix_word)
   );

   assign in_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign result      = r_result;
   assign out_rd_addr = r_rd;

endmodule
